// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_CNT_W    = 5;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;
endpackage

// File: rtl/rot_priority_encoder_8_3.sv
// MSB-first 8:3 priority encoder over a rotating window whose top slot is prio_top.
module rot_priority_encoder_8_3
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] prio_top,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_pos;

    // Bit j of w_rot is client prio_top+1+j, so prio_top lands on bit 7.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N_REQ; j++)
            w_rot[j] = req[IDX_W'(j) + prio_top + IDX_W'(1)];
    end

    always_comb begin
        w_pos = '0;
        for (int j = 0; j < N_REQ; j++)
            if (w_rot[j]) w_pos = IDX_W'(j);
    end

    assign idx = prio_top + IDX_W'(1) + w_pos;
    assign any = |req;
endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-client arbiter: registered one-hot grant held until done, abandon or hold limit.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter bit RR_EN    = 1'b1,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);
    arb_state_e       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_timeout;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0] r_prio_top;

    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic             w_owner_req;
    logic             w_limit;

    rot_priority_encoder_8_3 u_enc (
        .req      (req),
        .prio_top (r_prio_top),
        .idx      (w_pick),
        .any      (w_any)
    );

    assign w_owner_req = req[r_gnt_idx];
    assign w_limit     = (MAX_HOLD != 0) && (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
            r_prio_top  <= IDX_W'(N_REQ - 1);
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_gnt       <= N_REQ'(1) << w_pick;
                        r_gnt_idx   <= w_pick;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_state     <= ARB_GRANT;
                        // Winner drops to lowest priority for the next round.
                        if (RR_EN) r_prio_top <= w_pick - IDX_W'(1);
                    end
                end
                ARB_GRANT: begin
                    if (done || !w_owner_req || w_limit) begin
                        r_gnt       <= '0;
                        r_gnt_idx   <= '0;
                        r_gnt_valid <= 1'b0;
                        r_state     <= ARB_IDLE;
                        // Timeout only flags a release that nothing else explains.
                        r_timeout   <= !done && w_owner_req;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: round-robin, fixed-priority and short-hold-limit instances.
module tb_rr_arbiter_8;
    import arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;

    logic [7:0] gnt_a, gnt_b, gnt_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic       vld_a, vld_b, vld_c;
    logic       to_a,  to_b,  to_c;
    logic [12:0] obs_a, obs_b, obs_c;

    typedef struct packed {
        logic       r;
        logic [7:0] q;
        logic       d;
    } stim_t;

    stim_t       stim_q[$];
    logic [12:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.RR_EN(1'b1), .MAX_HOLD(16), .CNT_W(5)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .timeout(to_a));
    rr_arbiter_8 #(.RR_EN(1'b0), .MAX_HOLD(16), .CNT_W(5)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .timeout(to_b));
    rr_arbiter_8 #(.RR_EN(1'b1), .MAX_HOLD(4), .CNT_W(3)) dut_mh (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(vld_c), .timeout(to_c));

    assign obs_a = {gnt_a, idx_a, vld_a, to_a};
    assign obs_b = {gnt_b, idx_b, vld_b, to_b};
    assign obs_c = {gnt_c, idx_c, vld_c, to_c};

    // Expected {gnt, gnt_idx, gnt_valid, timeout}
    function automatic logic [12:0] pk(input int idx, input bit v, input bit to);
        return v ? {8'(1 << idx), 3'(idx), 1'b1, to} : {8'h00, 3'd0, 1'b0, to};
    endfunction

    task automatic push(input logic r, input logic [7:0] q, input logic d,
                        input logic [12:0] e, input string n);
        stim_q.push_back('{r: r, q: q, d: d});
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic test_reset();
        stim_t s; logic [12:0] e; string n;
        push(1, 8'h00, 0, pk(0, 0, 0), "reset_state");
        push(0, 8'h00, 0, pk(0, 0, 0), "idle_no_req");
        push(0, 8'h00, 1, pk(0, 0, 0), "done_in_idle");
        push(0, 8'h02, 1, pk(1, 1, 0), "grant_done_ignored_idle");
        push(0, 8'h02, 1, pk(0, 0, 0), "done_release");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); rst = s.r; req = s.q; done = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_a !== e) begin
                n_err++;
                $display("FAIL %s: got {gnt,idx,vld,to}=%h required %h", n, obs_a, e);
            end
        end
    endtask

    task automatic test_basic();
        stim_t s; logic [12:0] e; string n;
        push(1, 8'h00, 0, pk(0, 0, 0), "basic_rst");
        push(0, 8'h81, 0, pk(7, 1, 0), "basic_grant7");
        push(0, 8'h81, 1, pk(0, 0, 0), "basic_release");
        push(0, 8'h81, 0, pk(0, 1, 0), "basic_grant0");
        push(0, 8'h81, 1, pk(0, 0, 0), "basic_release2");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); rst = s.r; req = s.q; done = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_a !== e) begin
                n_err++;
                $display("FAIL %s: got {gnt,idx,vld,to}=%h required %h", n, obs_a, e);
            end
        end
    endtask

    task automatic test_rotation();
        stim_t s; logic [12:0] e; string n;
        push(1, 8'h00, 0, pk(0, 0, 0), "rot_rst");
        for (int k = 0; k < 9; k++) begin
            push(0, 8'hFF, 0, pk((7 - k) & 7, 1, 0), $sformatf("rot_grant%0d", k));
            push(0, 8'hFF, 1, pk(0, 0, 0), $sformatf("rot_idle%0d", k));
        end
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); rst = s.r; req = s.q; done = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_a !== e) begin
                n_err++;
                $display("FAIL %s: got {gnt,idx,vld,to}=%h required %h", n, obs_a, e);
            end
        end
    endtask

    task automatic test_fixed_prio();
        stim_t s; logic [12:0] e; string n;
        push(1, 8'h00, 0, pk(0, 0, 0), "fix_rst");
        for (int k = 0; k < 4; k++) begin
            push(0, 8'hFF, 0, pk(7, 1, 0), $sformatf("fix_grant%0d", k));
            push(0, 8'hFF, 1, pk(0, 0, 0), $sformatf("fix_idle%0d", k));
        end
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); rst = s.r; req = s.q; done = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_b !== e) begin
                n_err++;
                $display("FAIL %s: got {gnt,idx,vld,to}=%h required %h", n, obs_b, e);
            end
        end
    endtask

    task automatic test_hold_limit();
        stim_t s; logic [12:0] e; string n;
        push(1, 8'h00, 0, pk(0, 0, 0), "hold_rst");
        for (int k = 0; k < 4; k++) push(0, 8'h10, 0, pk(4, 1, 0), $sformatf("hold_c%0d", k));
        push(0, 8'h10, 0, pk(0, 0, 1), "hold_timeout_pulse");
        push(0, 8'h10, 0, pk(4, 1, 0), "hold_regrant");
        push(0, 8'h10, 1, pk(0, 0, 0), "hold_done_release");
        // done coinciding with the limit: no timeout
        for (int k = 0; k < 4; k++) push(0, 8'h10, 0, pk(4, 1, 0), $sformatf("dvl_c%0d", k));
        push(0, 8'h10, 1, pk(0, 0, 0), "done_beats_limit");
        // abandon coinciding with the limit: no timeout
        for (int k = 0; k < 4; k++) push(0, 8'h10, 0, pk(4, 1, 0), $sformatf("avl_c%0d", k));
        push(0, 8'h00, 0, pk(0, 0, 0), "abandon_beats_limit");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); rst = s.r; req = s.q; done = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_c !== e) begin
                n_err++;
                $display("FAIL %s: got {gnt,idx,vld,to}=%h required %h", n, obs_c, e);
            end
        end
    endtask

    task automatic test_abandon_and_mid_reset();
        stim_t s; logic [12:0] e; string n;
        push(1, 8'h00, 0, pk(0, 0, 0), "ab_rst");
        push(0, 8'h08, 0, pk(3, 1, 0), "ab_grant3");
        push(0, 8'h08, 0, pk(3, 1, 0), "ab_hold3");
        push(0, 8'h00, 0, pk(0, 0, 0), "ab_drop_no_timeout");
        push(0, 8'h20, 0, pk(5, 1, 0), "mr_grant5");
        push(1, 8'h20, 0, pk(0, 0, 0), "mr_reset_mid_grant");
        push(0, 8'h21, 0, pk(5, 1, 0), "mr_prio_top_restored");
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); rst = s.r; req = s.q; done = s.d;
            @(posedge clk); #1;
            e = exp_q.pop_front(); n = name_q.pop_front(); n_cmp++;
            if (obs_a !== e) begin
                n_err++;
                $display("FAIL %s: got {gnt,idx,vld,to}=%h required %h", n, obs_a, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = 8'h00; done = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_rotation();
        test_fixed_prio();
        test_hold_limit();
        test_abandon_and_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester arbiter sharing one resource (for example a bus port or a datapath lane) between up to 8 clients.
- Picks a winner with an MSB-first priority encode over a rotating priority window.
- Registers the grant and holds it until the owner signals done, drops its request, or exceeds a hold limit.
- Sits between request sources and the shared resource; gnt_idx drives the resource's input mux select directly.

Parameters:
- RR_EN, 1, 1 = round-robin rotation after each grant; 0 = fixed priority, bit 7 highest (pointer never moves).
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request vector, bit i = client i; level-sensitive.
- done  in  1  current owner finished; sampled only in GRANT.
- gnt  out  8  one-hot grant, registered; all zeros when idle.
- gnt_idx  out  3  binary index of the granted client; 0 when idle.
- gnt_valid  out  1  high while a grant is held (equals OR of gnt).
- timeout  out  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset, synchronous and active-high, takes effect at the next rising edge, including mid-grant. After that edge:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0
  - state=IDLE, hold_cnt=0, prio_top=7
- Priority pick (combinational):
  - Search order is prio_top, prio_top-1, ..., 0, 7, ... (descending, wrap 0->7).
  - The first set req bit wins.
  - With prio_top=7 this matches a plain MSB-first 8:3 priority encode.
- FSM has 2 states, IDLE and GRANT.
- IDLE:
  - If req != 0, the next edge loads gnt/gnt_idx with the pick, sets gnt_valid=1, clears hold_cnt and moves to GRANT.
  - Grant latency is 1 cycle from the cycle req is sampled.
  - If req == 0, stay in IDLE with outputs at 0.
- GRANT release conditions, checked in this priority order:
  1. done=1.
  2. req[gnt_idx]=0 (owner abandoned the resource).
  3. MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
- On release, the next edge sets gnt=0, gnt_idx=0, gnt_valid=0 and moves to IDLE.
  - If release was by condition 3 only, timeout=1 for exactly that one cycle.
  - If done and the limit coincide, done wins and timeout stays 0.
- If no release condition holds: hold_cnt increments and the grant is unchanged, regardless of other req bits.
- Pointer update happens on the edge that issues a grant to client k:
  - RR_EN=1: prio_top <= (k-1) mod 8, so client k becomes lowest priority. k=0 gives prio_top=7.
  - RR_EN=0: prio_top stays 7.
- There is always one idle cycle between back-to-back grants (release edge, then an arbitration edge).
- done asserted in IDLE is ignored.
- Requests arriving during GRANT are not queued; they are evaluated at the next IDLE edge from current req levels.
- gnt is always one-hot or zero, and gnt_idx is always consistent with gnt.

Decomposition:
- Shared package arb_pkg holds:
  - N_REQ=8, IDX_W=3
  - state enum {ARB_IDLE, ARB_GRANT}
  - default MAX_HOLD
- One natural combinational sub-module, rot_priority_encoder_8_3:
  - inputs: req[7:0], prio_top[2:0]; outputs: idx[2:0], any.
  - Implementation: rotate req so prio_top aligns to bit 7, do an MSB-first encode, then un-rotate the index.
- All registers live in the top module.

Test Plan:
- Reset then req=8'b1000_0001, RR_EN=1 -> next cycle gnt=8'h80, gnt_idx=7; done pulse -> gnt=0 next cycle; following edge gnt=8'h01, gnt_idx=0.
- All 8 requesting continuously, done pulsed every grant, RR_EN=1 -> gnt_idx sequence 7,6,5,4,3,2,1,0,7 with exactly one idle cycle between grants.
- RR_EN=0, req=8'hFF held, done every grant -> gnt_idx always 7.
- MAX_HOLD=4, req=8'h10 held, done=0 -> gnt=8'h10 for 4 cycles, then gnt=0 with timeout=1 for one cycle, then re-grant gnt_idx=4.
- Owner abandon: gnt_idx=3, drop req[3] -> gnt=0 next cycle, timeout=0; done+limit same cycle -> timeout=0.
- rst asserted while gnt=8'h20 -> next edge all outputs 0 and prio_top=7; with req=8'h21 the next grant is gnt_idx=5.
